decode_issue_stage: RTL

//  Parametrised decode/issue stage between fetch and execute. Holds one instruction with a valid/ready handshake on both sides.

---
 rtl/decode_issue_stage.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: one-entry skid between fetch and execute with immediate generation,
// priority bypass and load-use interlock. Optional feature macro: DSTAGE_BYPASS_EN.
module decode_issue_stage #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NUM_BYP = 3,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      f_vld,
    output logic                      f_rdy,
    input  logic [31:0]               f_instr,
    input  logic [XLEN-1:0]           f_pc,
    input  logic                      squash,
    input  logic [XLEN-1:0]           rs1_data,
    input  logic [XLEN-1:0]           rs2_data,
    output logic [4:0]                d_rs1,
    output logic [4:0]                d_rs2,
    input  logic [NUM_BYP-1:0]        byp_vld,
    input  logic [5*NUM_BYP-1:0]      byp_rd,
    input  logic [XLEN*NUM_BYP-1:0]   byp_data,
    input  logic [NUM_BYP-1:0]        byp_data_rdy,
    output logic                      x_vld,
    input  logic                      x_rdy,
    output logic [XLEN-1:0]           x_op1,
    output logic [XLEN-1:0]           x_op2,
    output logic [XLEN-1:0]           x_rs2_val,
    output logic [XLEN-1:0]           x_pc,
    output logic [XLEN-1:0]           x_pc_plus4,
    output logic [XLEN-1:0]           x_br_tgt,
    output logic [3:0]                x_alu_op,
    output logic [4:0]                x_rd,
    output logic                      x_wr_en,
    output logic                      x_dmem_vld,
    output logic                      x_dmem_mtype,
    output logic [1:0]                x_dmem_len,
    output logic                      x_illegal,
    output logic [CNT_W-1:0]          stall_cnt
);

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_RI     = 7'b0010011,
        OP_RR     = 7'b0110011,
        OP_FENCE  = 7'b0001111,
        OP_SYSTEM = 7'b1110011
    } opcode_e;

    logic              d_vld;
    logic [31:0]       d_instr;
    logic [XLEN-1:0]   d_pc;
    logic [CNT_W-1:0]  stall_q;

    logic [6:0]        opc;
    logic [2:0]        funct3;
    logic              is_lui, is_auipc, is_jal, is_jalr, is_branch;
    logic              is_load, is_store, is_ri, is_rr, is_fence, is_system;
    logic              use1, use2;
    logic [31:0]       imm32;
    logic [XLEN-1:0]   imm;
    logic              hit1, hit2, pend1, pend2;
    logic [XLEN-1:0]   val1, val2;
    logic              hazard;
    logic              f_fire, x_fire;

    assign opc       = d_instr[6:0];
    assign funct3    = d_instr[14:12];
    assign d_rs1     = d_instr[19:15];
    assign d_rs2     = d_instr[24:20];
    assign is_lui    = (opc == OP_LUI);
    assign is_auipc  = (opc == OP_AUIPC);
    assign is_jal    = (opc == OP_JAL);
    assign is_jalr   = (opc == OP_JALR);
    assign is_branch = (opc == OP_BRANCH);
    assign is_load   = (opc == OP_LOAD);
    assign is_store  = (opc == OP_STORE);
    assign is_ri     = (opc == OP_RI);
    assign is_rr     = (opc == OP_RR);
    assign is_fence  = (opc == OP_FENCE);
    assign is_system = (opc == OP_SYSTEM);

    assign use1 = !(is_lui || is_auipc || is_jal);
    assign use2 = is_rr || is_branch || is_store;

    always_comb begin
        imm32 = {{20{d_instr[31]}}, d_instr[31:20]};
        if (is_lui || is_auipc)
            imm32 = {d_instr[31:12], 12'b0};
        else if (is_jal)
            imm32 = {{12{d_instr[31]}}, d_instr[19:12], d_instr[20], d_instr[30:21], 1'b0};
        else if (is_branch)
            imm32 = {{20{d_instr[31]}}, d_instr[7], d_instr[30:25], d_instr[11:8], 1'b0};
        else if (is_store)
            imm32 = {{20{d_instr[31]}}, d_instr[31:25], d_instr[11:7]};
    end
    assign imm = XLEN'($signed(imm32));

    // Ascending scan with a first-hit latch gives the youngest stage priority; x0 never matches.
    always_comb begin
        hit1  = 1'b0;
        hit2  = 1'b0;
        pend1 = 1'b0;
        pend2 = 1'b0;
        val1  = rs1_data;
        val2  = rs2_data;
        for (int unsigned k = 0; k < NUM_BYP; k++) begin
            if (!hit1 && d_rs1 != 5'd0 && byp_vld[k] && byp_rd[5*k +: 5] == d_rs1) begin
                hit1 = 1'b1;
`ifdef DSTAGE_BYPASS_EN
                pend1 = !byp_data_rdy[k];
                val1  = byp_data[XLEN*k +: XLEN];
`else
                pend1 = 1'b1;
`endif
            end
            if (!hit2 && d_rs2 != 5'd0 && byp_vld[k] && byp_rd[5*k +: 5] == d_rs2) begin
                hit2 = 1'b1;
`ifdef DSTAGE_BYPASS_EN
                pend2 = !byp_data_rdy[k];
                val2  = byp_data[XLEN*k +: XLEN];
`else
                pend2 = 1'b1;
`endif
            end
        end
    end

`ifndef DSTAGE_BYPASS_EN
    logic unused_byp;
    assign unused_byp = ^{byp_data, byp_data_rdy};
`endif

    assign hazard = (use1 && pend1) || (use2 && pend2);
    assign x_vld  = d_vld && !hazard && !squash;
    assign x_fire = x_vld && x_rdy;
    assign f_rdy  = !d_vld || x_fire;
    assign f_fire = f_vld && f_rdy;

    assign x_op1        = is_lui ? '0 : ((is_auipc || is_jal) ? d_pc : val1);
    assign x_op2        = (is_rr || is_branch) ? val2 : imm;
    assign x_rs2_val    = val2;
    assign x_pc         = d_pc;
    assign x_pc_plus4   = d_pc + XLEN'(4);
    assign x_br_tgt     = d_pc + imm;
    assign x_alu_op     = (is_rr || is_ri)
                          ? {d_instr[30] && !(is_ri && funct3 != 3'b101), funct3} : 4'd0;
    assign x_rd         = d_instr[11:7];
    assign x_wr_en      = (is_lui || is_auipc || is_jal || is_jalr || is_load || is_ri || is_rr)
                          && (x_rd != 5'd0);
    assign x_dmem_vld   = is_load || is_store;
    assign x_dmem_mtype = is_store;
    assign x_dmem_len   = (funct3[1:0] == 2'b00) ? 2'd1 : ((funct3[1:0] == 2'b01) ? 2'd2 : 2'd0);
    assign x_illegal    = !(is_lui || is_auipc || is_jal || is_jalr || is_branch || is_load ||
                            is_store || is_ri || is_rr || is_fence || is_system);
    assign stall_cnt    = stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_vld   <= 1'b0;
            d_instr <= '0;
            d_pc    <= '0;
            stall_q <= '0;
        end else begin
            if (squash)
                d_vld <= 1'b0;
            else if (f_fire)
                d_vld <= 1'b1;
            else if (x_fire)
                d_vld <= 1'b0;
            if (f_fire) begin
                d_instr <= f_instr;
                d_pc    <= f_pc;
            end
            if (d_vld && hazard && !squash && stall_q != '1)
                stall_q <= stall_q + CNT_W'(1);
        end
    end

endmodule
